// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES key schedule.
// Loads a 64-bit key through PC-1, then steps the C/D halves once per accepted
// subkey handshake. Each subkey is PC-2 of the current C/D registers.
// Encrypt order K1..K16 rotates left; decrypt order K16..K1 rotates right.
// Optional feature macro: DES_KS_PARITY_CHECK_EN (odd-parity check per key byte,
// reported on key_err). Without it key_err is tied low.
module des_key_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        decrypt,
   input  logic [1:64] key_in,
   input  logic        sk_ready,
   output logic        sk_valid,
   output logic [1:48] subkey_out,
   output logic [4:0]  round_idx,
   output logic        busy,
   output logic        done,
   output logic        key_err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [1:28] c_reg;
   logic [1:28] d_reg;
   logic [4:0]  round;
   logic        dir;

   logic [1:56] pc1_key;
   logic [1:28] c_load;
   logic [1:28] d_load;
   logic [4:0]  next_round;
   logic [4:0]  shift_idx;
   logic        two_step;
   logic [1:28] c_next;
   logic [1:28] d_next;

   // PC-1: drops the eight parity bits and splits the key into C (1..28) and D (29..56).
   function automatic logic [1:56] pc1(input logic [1:64] k);
      return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
              k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
              k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
              k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
              k[63], k[55], k[47], k[39], k[31], k[23], k[15],
              k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
              k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
              k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
   endfunction

   // PC-2: selects 48 of the 56 C/D bits to form a round subkey.
   function automatic logic [1:48] pc2(input logic [1:56] cd);
      return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
              cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
              cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
              cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
              cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
              cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
              cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
              cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
   endfunction

   // Bit 1 is the MSB, so a left rotate moves bit 1 to position 28.
   function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
      return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
   endfunction

   function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
      return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
   endfunction

   // DES shift schedule: rounds 1, 2, 9 and 16 rotate by one, all others by two.
   function automatic logic shift_is_two(input logic [4:0] i);
      return !((i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16));
   endfunction

   assign pc1_key = pc1(key_in);

   // Encrypt starts at C1D1 (one left rotate); decrypt starts at C0D0, which equals C16D16.
   assign c_load = decrypt ? pc1_key[1:28]  : rotl(pc1_key[1:28], 1'b0);
   assign d_load = decrypt ? pc1_key[29:56] : rotl(pc1_key[29:56], 1'b0);

   // Next C/D for the round being entered; decrypt walks the schedule backwards.
   always_comb begin
      next_round = round + 5'd1;
      shift_idx  = dir ? (5'd18 - next_round) : next_round;
      two_step   = shift_is_two(shift_idx);
      c_next     = dir ? rotr(c_reg, two_step) : rotl(c_reg, two_step);
      d_next     = dir ? rotr(d_reg, two_step) : rotl(d_reg, two_step);
   end

   // Control FSM plus C/D key state; advances only on a subkey handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         c_reg    <= '0;
         d_reg    <= '0;
         round    <= '0;
         dir      <= 1'b0;
         sk_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  c_reg    <= c_load;
                  d_reg    <= d_load;
                  dir      <= decrypt;
                  round    <= 5'd1;
                  sk_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (sk_ready) begin
                  if (round == 5'd16) begin
                     round    <= '0;
                     sk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     round <= next_round;
                     c_reg <= c_next;
                     d_reg <= d_next;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign subkey_out = sk_valid ? pc2({c_reg, d_reg}) : '0;
   assign round_idx  = round;

`ifdef DES_KS_PARITY_CHECK_EN
   logic parity_fail;

   // A byte fails when its XOR is 0 (even number of ones).
   assign parity_fail = ~(^key_in[1:8])   | ~(^key_in[9:16])  |
                        ~(^key_in[17:24]) | ~(^key_in[25:32]) |
                        ~(^key_in[33:40]) | ~(^key_in[41:48]) |
                        ~(^key_in[49:56]) | ~(^key_in[57:64]);

   // Parity flag captured with each accepted start and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_err <= 1'b0;
      end else if (state == IDLE && start) begin
         key_err <= parity_fail;
      end
   end
`else
   assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic key 0x133457799BBCDFF1.
module tb_des_key_schedule;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        decrypt;
   logic [1:64] key_in;
   logic        sk_ready;
   logic        sk_valid;
   logic [1:48] subkey_out;
   logic [4:0]  round_idx;
   logic        busy;
   logic        done;
   logic        key_err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:64] KEY_A   = 64'h133457799BBCDFF1;
   localparam logic [1:64] KEY_BAD = 64'h133457799BBCDFF0;
   localparam logic [1:64] KEY_B   = 64'h0123456789ABCDEF;
   localparam logic [1:48] K1_A    = 48'h1B02EFFC7072;
   localparam logic [1:48] K2_A    = 48'h79AED9DBC9E5;
   localparam logic [1:48] K16_A   = 48'hCB3D8B0E17F5;

   logic [1:48] enc_seq [1:16];

   des_key_schedule dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .decrypt    (decrypt),
      .key_in     (key_in),
      .sk_ready   (sk_ready),
      .sk_valid   (sk_valid),
      .subkey_out (subkey_out),
      .round_idx  (round_idx),
      .busy       (busy),
      .done       (done),
      .key_err    (key_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: Kn = PC-2 of PC-1 halves each rotated left by the cumulative shift count.
   function automatic logic [1:48] ref_subkey(input logic [1:64] k, input int n);
      logic [1:56] pk;
      logic [55:0] cc;
      logic [55:0] dd;
      logic [1:56] cd;
      int s;
      s = 0;
      for (int j = 1; j <= n; j++) s += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
      pk = {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
            k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
            k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
            k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
            k[63], k[55], k[47], k[39], k[31], k[23], k[15],
            k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
            k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
            k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
      cc = {pk[1:28], pk[1:28]} << s;
      dd = {pk[29:56], pk[29:56]} << s;
      cd = {cc[55:28], dd[55:28]};
      return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
              cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
              cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
              cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
              cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
              cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
              cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
              cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:64] k, input logic dec);
      key_in  = k;
      decrypt = dec;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key_in = '0; sk_ready = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({sk_valid, busy, done, key_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000", {sk_valid, busy, done, key_err});
      end
      n_checks++;
      if (subkey_out !== 48'h0 || round_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_data: subkey %h round %0d required 0 and 0", subkey_out, round_idx);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_encrypt;
      do_start(KEY_A, 1'b0);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL enc_busy: got %b required 1", busy);
      end
      for (int r = 1; r <= 16; r++) begin
         n_checks++;
         if (sk_valid !== 1'b1 || round_idx !== 5'(r)) begin
            n_fail++;
            $display("FAIL enc_round: valid %b round %0d required 1 and %0d", sk_valid, round_idx, r);
         end
         n_checks++;
         if (subkey_out !== ref_subkey(KEY_A, r)) begin
            n_fail++;
            $display("FAIL enc_subkey%0d: got %h required %h", r, subkey_out, ref_subkey(KEY_A, r));
         end
         enc_seq[r] = subkey_out;
         if (r == 1) begin
            n_checks++;
            if (subkey_out !== K1_A) begin
               n_fail++;
               $display("FAIL enc_k1: got %h required %h", subkey_out, K1_A);
            end
         end
         if (r == 2) begin
            n_checks++;
            if (subkey_out !== K2_A) begin
               n_fail++;
               $display("FAIL enc_k2: got %h required %h", subkey_out, K2_A);
            end
         end
         if (r == 16) begin
            n_checks++;
            if (subkey_out !== K16_A) begin
               n_fail++;
               $display("FAIL enc_k16: got %h required %h", subkey_out, K16_A);
            end
         end
         tick();
      end
      n_checks++;
      if ({done, busy, sk_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL enc_done: done/busy/valid %b required 100", {done, busy, sk_valid});
      end
      n_checks++;
      if (subkey_out !== 48'h0 || round_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL enc_idle_out: subkey %h round %0d required 0", subkey_out, round_idx);
      end
      n_checks++;
      if (key_err !== 1'b0) begin
         n_fail++;
         $display("FAIL enc_key_err: got %b required 0", key_err);
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL enc_done_pulse: got %b required 0", done);
      end
   endtask

   task automatic test_decrypt;
      do_start(KEY_A, 1'b1);
      for (int r = 1; r <= 16; r++) begin
         n_checks++;
         if (round_idx !== 5'(r) || subkey_out !== enc_seq[17 - r]) begin
            n_fail++;
            $display("FAIL dec_subkey%0d: round %0d got %h required %h", r, round_idx, subkey_out, enc_seq[17 - r]);
         end
         if (r == 1) begin
            n_checks++;
            if (subkey_out !== K16_A) begin
               n_fail++;
               $display("FAIL dec_first: got %h required %h", subkey_out, K16_A);
            end
         end
         if (r == 16) begin
            n_checks++;
            if (subkey_out !== K1_A) begin
               n_fail++;
               $display("FAIL dec_last: got %h required %h", subkey_out, K1_A);
            end
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_done: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_backpressure;
      do_start(KEY_A, 1'b0);
      for (int r = 1; r <= 16; r++) begin
         n_checks++;
         if (round_idx !== 5'(r) || subkey_out !== enc_seq[r]) begin
            n_fail++;
            $display("FAIL bp_subkey%0d: round %0d got %h required %h", r, round_idx, subkey_out, enc_seq[r]);
         end
         if (r == 7) begin
            sk_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               tick();
               n_checks++;
               if (sk_valid !== 1'b1 || round_idx !== 5'd7 || subkey_out !== enc_seq[7]) begin
                  n_fail++;
                  $display("FAIL bp_hold: valid %b round %0d subkey %h required 1, 7, %h", sk_valid, round_idx, subkey_out, enc_seq[7]);
               end
            end
            sk_ready = 1'b1;
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_done: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_start_ignored;
      do_start(KEY_A, 1'b0);
      for (int r = 1; r <= 16; r++) begin
         n_checks++;
         if (round_idx !== 5'(r) || subkey_out !== enc_seq[r]) begin
            n_fail++;
            $display("FAIL ign_subkey%0d: round %0d got %h required %h", r, round_idx, subkey_out, enc_seq[r]);
         end
         if (r == 4) begin
            key_in = KEY_B; decrypt = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL ign_done: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      do_start(KEY_A, 1'b0);
      repeat (16) tick();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done: got %b required 1", done);
      end
      do_start(KEY_A, 1'b1);
      n_checks++;
      if (sk_valid !== 1'b1 || round_idx !== 5'd1 || subkey_out !== K16_A || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_restart: valid %b round %0d subkey %h done %b required 1, 1, %h, 0", sk_valid, round_idx, subkey_out, done, K16_A);
      end
      repeat (16) tick();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done2: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_parity;
`ifdef DES_KS_PARITY_CHECK_EN
      do_start(KEY_BAD, 1'b0);
      n_checks++;
      if (key_err !== 1'b1) begin
         n_fail++;
         $display("FAIL par_bad: got %b required 1", key_err);
      end
`else
      do_start(KEY_BAD, 1'b0);
      n_checks++;
      if (key_err !== 1'b0) begin
         n_fail++;
         $display("FAIL par_tied: got %b required 0", key_err);
      end
`endif
      n_checks++;
      if (subkey_out !== K1_A) begin
         n_fail++;
         $display("FAIL par_k1: got %h required %h", subkey_out, K1_A);
      end
      for (int r = 1; r <= 16; r++) begin
         n_checks++;
         if (subkey_out !== ref_subkey(KEY_BAD, r)) begin
            n_fail++;
            $display("FAIL par_subkey%0d: got %h required %h", r, subkey_out, ref_subkey(KEY_BAD, r));
         end
         tick();
      end
`ifdef DES_KS_PARITY_CHECK_EN
      n_checks++;
      if (key_err !== 1'b1) begin
         n_fail++;
         $display("FAIL par_hold: got %b required 1", key_err);
      end
`endif
      tick();
      do_start(KEY_A, 1'b0);
      n_checks++;
      if (key_err !== 1'b0) begin
         n_fail++;
         $display("FAIL par_good: got %b required 0", key_err);
      end
      repeat (16) tick();
      tick();
   endtask

   task automatic test_reset_midrun;
      do_start(KEY_A, 1'b0);
      repeat (9) tick();
      n_checks++;
      if (round_idx !== 5'd10 || subkey_out !== enc_seq[10]) begin
         n_fail++;
         $display("FAIL rst_pre: round %0d subkey %h required 10, %h", round_idx, subkey_out, enc_seq[10]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sk_valid, busy, done, key_err} !== 4'b0000 || subkey_out !== 48'h0 || round_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL rst_async: flags %b subkey %h round %0d required 0", {sk_valid, busy, done, key_err}, subkey_out, round_idx);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || sk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: done %b valid %b required 0 0", done, sk_valid);
         end
      end
      rst_n = 1'b1;
      tick();
      do_start(KEY_A, 1'b0);
      n_checks++;
      if (sk_valid !== 1'b1 || round_idx !== 5'd1 || subkey_out !== K1_A) begin
         n_fail++;
         $display("FAIL rst_restart: valid %b round %0d subkey %h required 1, 1, %h", sk_valid, round_idx, subkey_out, K1_A);
      end
      repeat (17) tick();
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_start_ignored();
      test_back_to_back();
      test_parity();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key schedule. It accepts a 64-bit key and emits the sixteen 48-bit round subkeys in order, one per accepted handshake. Encrypt order is K1..K16; decrypt order is K16..K1. It sits directly upstream of the round function: each subkey is XORed with the 48-bit expansion output, and the result feeds the eight S-box lookups (SBox1..SBox8).

## Interface
Parameters:
- none. The DES tables (PC-1, PC-2, shift schedule) are fixed.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to load `key_in` and begin a schedule; sampled only in IDLE.
- decrypt  input  1  sampled together with `start`; 0 gives K1→K16, 1 gives K16→K1.
- key_in  input  [1:64]  DES key in standard bit numbering (bit 1 = MSB); parity bits 8,16,…,64 included.
- sk_ready  input  1  the round datapath accepts the current subkey.
- sk_valid  output  1  `subkey_out` and `round_idx` are valid.
- subkey_out  output  [1:48]  PC-2 of the current C/D registers; forced to 0 when `sk_valid`=0.
- round_idx  output  [4:0]  round number 1..16 in consumption order; 0 when idle.
- busy  output  1  high from the cycle after `start` is accepted until the final handshake.
- done  output  1  one-cycle pulse in the cycle after the 16th handshake.
- key_err  output  1  parity flag; see Configuration.

## Operation
- Registers:
  - C[1:28] and D[1:28] hold the rotated key halves.
  - A 5-bit round counter tracks progress.
  - A direction bit holds the latched `decrypt` value.
  - The state register is IDLE or RUN.
- IDLE, on `start`=1:
  - Compute {C,D} = PC-1(`key_in`).
  - Encrypt: load C and D each rotated left by 1.
  - Decrypt: load C and D unrotated, because C0D0 equals C16D16.
  - Set round = 1 and go to RUN.
- RUN:
  - `sk_valid`=1, and `subkey_out` = PC-2(C,D).
  - A handshake (`sk_valid` & `sk_ready`) with round < 16 increments round, then:
    - Encrypt: rotate C and D left by shift(round+1).
    - Decrypt: rotate C and D right by shift(18 − (round+1)).
  - shift(i) = 1 for i ∈ {1,2,9,16}, otherwise 2.
  - A handshake with round = 16 returns to IDLE, clears the round counter and pulses `done`.
- Without a handshake (`sk_ready`=0), C, D, round and `subkey_out` hold stable.
- `start` during RUN is ignored, and `key_in`/`decrypt` are not re-sampled.
- `start` in the same cycle as `done` is accepted, because the block is already IDLE in that cycle.
- C, D and round are only updated in the cases above; nothing else modifies them.

## Timing
- Reset values: `sk_valid` 0, `subkey_out` 0, `round_idx` 0, `busy` 0, `done` 0, `key_err` 0; state IDLE; C, D and direction 0.
- Asserting `rst_n` mid-schedule aborts it immediately and asynchronously, with no `done` pulse.
- Latency:
  - `start` sampled at edge N → `sk_valid`=1 with round 1 after edge N.
  - Each handshake at edge M → the next subkey is valid after edge M.
- Throughput: with `sk_ready` held at 1, a full schedule takes 16 cycles of `sk_valid`, followed by `done` on cycle 17.
- `subkey_out` is combinational from registers only (PC-2 is a pure wiring permutation); there are no input-to-output combinational paths.

## Configuration
- The feature is gated by `DES_KS_PARITY_CHECK_EN`.
- Defined:
  - On the accepted `start`, each key byte `key_in`[8k−7:8k] is checked for odd parity.
  - `key_err` registers the OR of all byte failures.
  - `key_err` holds that value until the next accepted `start` or reset.
  - The schedule runs regardless of `key_err`.
- Undefined: `key_err` is tied to 0 and no parity logic is built.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, `sk_ready`=1 → round 1 subkey 0x1B02EFFC7072 and round 16 subkey 0xCB3D8B0E17F5; `done` is high one cycle later; `key_err`=0 when the macro is defined.
- Decrypt, same key → round_idx 1 shows 0xCB3D8B0E17F5 and round_idx 16 shows 0x1B02EFFC7072; all 16 subkeys are the exact reverse of the encrypt run.
- Backpressure: drop `sk_ready` for 5 cycles at round 7 → `subkey_out` and `round_idx`=7 are stable throughout; the sequence is then unchanged from the free-running run.
- `start` pulsed at round 4 with a different key → ignored; the output sequence matches the original key.
- Parity, macro defined: key 0x133457799BBCDFF0 → `key_err`=1 after the start edge, and the subkeys match the table for that key. Restart with 0x133457799BBCDFF1 → `key_err`=0.
- Reset: deassert then assert `rst_n` at round 10 → all outputs return to 0 asynchronously with no `done` pulse; a fresh `start` then produces round 1 normally.
